mips_mem_responder: RTL and testbench

//   Memory-side responder for the 8-bit multicycle MIPS core bus (adr/writedata out, memdata in).

---
 rtl/mips_mem_responder.sv | 130 +++++++++++++
 tb/tb_mips_mem_responder.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mips_mem_responder.sv
// mips_mem_responder: memory-side responder for the 8-bit multicycle MIPS core bus.
// Holds program/data RAM. A valid/ready loader port fills the RAM while the core
// is held in reset. After that the core is released and its reads and writes are served.
//
// Ports:
//   clk, reset                  single clock; synchronous active-high reset
//   adr, writedata              core address / write data
//   memread, memwrite           core read / write strobes (honoured in RUN only)
//   memdata                     registered read data, 1-cycle latency, held while idle
//   ld_valid, ld_data, ld_last  loader word stream
//   ld_ready                    loader word accepted this cycle (LOAD state)
//   cpu_reset                   core reset, high until one cycle after loading ends
//   loaded                      high in RUN
//   wprot_err                   sticky write-protect violation flag
//
// Optional feature: define MIPS_MEM_WPROT_EN to drop RUN writes below PROT_TOP
// and flag them on wprot_err. When the macro is undefined, wprot_err stays 0.
module mips_mem_responder #(
  parameter int unsigned       AWIDTH   = 8,
  parameter int unsigned       DWIDTH   = 8,
  parameter logic [AWIDTH-1:0] PROT_TOP = AWIDTH'(8'h80)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [AWIDTH-1:0] adr,
  input  logic [DWIDTH-1:0] writedata,
  input  logic              memread,
  input  logic              memwrite,
  output logic [DWIDTH-1:0] memdata,
  input  logic              ld_valid,
  input  logic [DWIDTH-1:0] ld_data,
  input  logic              ld_last,
  output logic              ld_ready,
  output logic              cpu_reset,
  output logic              loaded,
  output logic              wprot_err
);

  localparam int unsigned       DEPTH   = 2 ** AWIDTH;
  localparam logic [AWIDTH-1:0] PTR_MAX = AWIDTH'(DEPTH - 1);

`ifdef MIPS_MEM_WPROT_EN
  localparam bit WPROT_EN = 1'b1;
`else
  localparam bit WPROT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_LOAD    = 2'd0,
    S_RELEASE = 2'd1,
    S_RUN     = 2'd2
  } state_t;

  state_t            state;
  logic [AWIDTH-1:0] ld_ptr;
  logic [DWIDTH-1:0] mem [DEPTH];

  logic              prot_hit_c;
  logic              mem_we_c;
  logic [AWIDTH-1:0] mem_waddr_c;
  logic [DWIDTH-1:0] mem_wdata_c;

  // A core write into the protected region (constant 0 when protection is compiled out)
  assign prot_hit_c = WPROT_EN && (adr < PROT_TOP);

  // RAM write port: the loader owns it in LOAD, and the core owns it in RUN
  always_comb begin
    mem_we_c    = 1'b0;
    mem_waddr_c = adr;
    mem_wdata_c = writedata;
    if (!reset) begin
      if (state == S_LOAD && ld_valid) begin
        mem_we_c    = 1'b1;
        mem_waddr_c = ld_ptr;
        mem_wdata_c = ld_data;
      end else if (state == S_RUN && memwrite && !prot_hit_c) begin
        mem_we_c = 1'b1;
      end
    end
  end

  // RAM storage is not reset, so its contents survive a reset during RUN
  always_ff @(posedge clk) begin
    if (mem_we_c) mem[mem_waddr_c] <= mem_wdata_c;
  end

  // Load / release / run sequencing with registered Moore outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_LOAD;
      ld_ptr    <= '0;
      memdata   <= '0;
      ld_ready  <= 1'b1;
      cpu_reset <= 1'b1;
      loaded    <= 1'b0;
      wprot_err <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (ld_valid) begin
            // The pointer saturates at the top word instead of wrapping to 0
            if (ld_ptr != PTR_MAX) ld_ptr <= ld_ptr + AWIDTH'(1);
            if (ld_last || ld_ptr == PTR_MAX) begin
              state    <= S_RELEASE;
              ld_ready <= 1'b0;
            end
          end
        end
        S_RELEASE: begin
          // Core reset was held for one extra cycle so the core samples it
          state     <= S_RUN;
          cpu_reset <= 1'b0;
          loaded    <= 1'b1;
        end
        S_RUN: begin
          // The read sees the pre-write word, so a read and write to the same address return the old data
          if (memread) memdata <= mem[adr];
          if (memwrite && prot_hit_c) wprot_err <= 1'b1;
        end
        default: begin
          state     <= S_LOAD;
          ld_ready  <= 1'b1;
          cpu_reset <= 1'b1;
          loaded    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_mem_responder.sv
// Testbench for mips_mem_responder. It uses randomized loader and core traffic,
// checked against a word-array reference model of the RAM and the load/release/run sequence.
module tb_mips_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] adr;
  logic [7:0] writedata;
  logic       memread;
  logic       memwrite;
  logic [7:0] memdata;
  logic       ld_valid;
  logic [7:0] ld_data;
  logic       ld_last;
  logic       ld_ready;
  logic       cpu_reset;
  logic       loaded;
  logic       wprot_err;

`ifdef MIPS_MEM_WPROT_EN
  localparam bit WPROT = 1'b1;
`else
  localparam bit WPROT = 1'b0;
`endif
  localparam logic [7:0] PROT_TOP = 8'h80;

  mips_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .adr       (adr),
    .writedata (writedata),
    .memread   (memread),
    .memwrite  (memwrite),
    .memdata   (memdata),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_last   (ld_last),
    .ld_ready  (ld_ready),
    .cpu_reset (cpu_reset),
    .loaded    (loaded),
    .wprot_err (wprot_err)
  );

  always #5 clk = ~clk;

  // Reference model: RAM image, which words are known, last read result, sticky error
  logic [7:0] ref_mem [256];
  bit         known   [256];
  logic [7:0] exp_md;
  logic       exp_wprot;
  logic [7:0] prog [4];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stream n words through the loader, then check the release handshake
  task automatic load_words(input int n, input bit use_last, input bit fixed);
    logic [7:0] d;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        ld_valid = 1'b0;
        step();
        check("ld_ready_gap", 32'(ld_ready), 32'd1);
      end
      d        = fixed ? prog[i] : 8'($urandom);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = use_last && (i == n - 1);
      ref_mem[i] = d;
      known[i]   = 1'b1;
      step();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      if (i < n - 1) check("ld_ready_load", 32'(ld_ready), 32'd1);
    end
    check("ld_ready_fall", 32'(ld_ready), 32'd0);
    check("cpu_reset_release", 32'(cpu_reset), 32'd1);
    check("loaded_release", 32'(loaded), 32'd0);
    step();
    check("cpu_reset_run", 32'(cpu_reset), 32'd0);
    check("loaded_run", 32'(loaded), 32'd1);
  endtask

  // Core write alone: commits unless it hits the protected region
  task automatic core_write(input logic [7:0] a, input logic [7:0] d);
    adr = a; writedata = d; memwrite = 1'b1;
    step();
    memwrite = 1'b0;
    if (WPROT && a < PROT_TOP) exp_wprot = 1'b1;
    else begin ref_mem[a] = d; known[a] = 1'b1; end
  endtask

  // Core read and, optionally, a write to the same address in the same cycle
  task automatic core_read(input logic [7:0] a, input bit also_write, input logic [7:0] d);
    adr = a; memread = 1'b1; memwrite = also_write; writedata = d;
    step();
    memread = 1'b0; memwrite = 1'b0;
    if (known[a]) begin
      exp_md = ref_mem[a];
      check(also_write ? "rdwr_old" : "read", 32'(memdata), 32'(exp_md));
    end
    if (also_write) begin
      if (WPROT && a < PROT_TOP) exp_wprot = 1'b1;
      else begin ref_mem[a] = d; known[a] = 1'b1; end
    end
  endtask

  task automatic idle_hold(input int n);
    for (int i = 0; i < n; i++) begin
      adr = 8'($urandom);
      step();
    end
    check("memdata_hold", 32'(memdata), 32'(exp_md));
  endtask

  initial begin
    prog[0] = 8'h20; prog[1] = 8'h01; prog[2] = 8'h02; prog[3] = 8'h03;
    for (int i = 0; i < 256; i++) begin ref_mem[i] = '0; known[i] = 1'b0; end
    exp_md = '0; exp_wprot = 1'b0;
    reset = 1'b1; adr = '0; writedata = '0; memread = 1'b0; memwrite = 1'b0;
    ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    step(); step();
    reset = 1'b0;
    check("rst_ld_ready", 32'(ld_ready), 32'd1);
    check("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rst_loaded", 32'(loaded), 32'd0);
    check("rst_memdata", 32'(memdata), 32'd0);
    check("rst_wprot_err", 32'(wprot_err), 32'd0);

    // Core strobes are ignored while loading
    adr = 8'h00; writedata = 8'hEE; memread = 1'b1; memwrite = 1'b1;
    step();
    memread = 1'b0; memwrite = 1'b0;
    check("load_ignores_read", 32'(memdata), 32'd0);

    // Four-word program, then read, hold, write and read-first behaviour
    load_words(4, 1'b1, 1'b1);
    core_read(8'h02, 1'b0, 8'h00);
    check("read_0x02", 32'(memdata), 32'h02);
    idle_hold(3);
    core_write(8'h90, 8'hA5);
    core_read(8'h90, 1'b0, 8'h00);
    check("read_0x90", 32'(memdata), 32'hA5);
    core_read(8'h90, 1'b1, 8'h5A);
    check("rdwr_0x90", 32'(memdata), 32'hA5);
    core_read(8'h90, 1'b0, 8'h00);
    check("read_0x90_new", 32'(memdata), 32'h5A);
    core_read(8'h00, 1'b0, 8'h00);
    check("word0_kept", 32'(memdata), 32'h20);

    // Full 256-word load without ld_last: release follows word 255
    reset = 1'b1; step(); reset = 1'b0;
    exp_md = '0; exp_wprot = 1'b0;
    load_words(256, 1'b0, 1'b0);

    // Loader traffic in RUN must not touch RAM
    for (int i = 0; i < 8; i++) begin
      ld_valid = 1'b1; ld_data = 8'($urandom); ld_last = 1'($urandom);
      step();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    check("ld_ready_run", 32'(ld_ready), 32'd0);
    for (int i = 0; i < 8; i++) core_read(8'(i), 1'b0, 8'h00);
    core_read(8'hFF, 1'b0, 8'h00);

    // Write to a low address: dropped and flagged only with protection
    check("wprot_before", 32'(wprot_err), 32'd0);
    core_write(8'h10, 8'hFF);
    core_read(8'h10, 1'b0, 8'h00);
    check("mem_0x10", 32'(memdata), WPROT ? 32'(exp_md) : 32'hFF);
    check("wprot_0x10", 32'(wprot_err), WPROT ? 32'd1 : 32'd0);

    // Randomized core traffic
    for (int k = 0; k < 300; k++) begin
      case ($urandom_range(3))
        0: core_read(8'($urandom), 1'b0, 8'h00);
        1: core_write(8'($urandom), 8'($urandom));
        2: core_read(8'($urandom), 1'b1, 8'($urandom));
        default: idle_hold(int'($urandom_range(1, 3)));
      endcase
    end
    check("wprot_random", 32'(wprot_err), 32'(exp_wprot));

    // Reset mid-RUN: back to LOAD, RAM preserved beyond the reloaded word
    reset = 1'b1; step(); reset = 1'b0;
    exp_md = '0; exp_wprot = 1'b0;
    check("rerst_cpu_reset", 32'(cpu_reset), 32'd1);
    check("rerst_memdata", 32'(memdata), 32'd0);
    check("rerst_loaded", 32'(loaded), 32'd0);
    check("rerst_ld_ready", 32'(ld_ready), 32'd1);
    check("rerst_wprot", 32'(wprot_err), 32'd0);
    load_words(1, 1'b1, 1'b0);
    core_read(8'h00, 1'b0, 8'h00);
    core_read(8'h01, 1'b0, 8'h00);
    check("word1_preserved", 32'(memdata), 32'(ref_mem[1]));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
